// File: rtl/nn_frame_loader.sv
// nn_frame_loader: thresholds a row-major pixel stream into a 28x28 binary frame, launches the nn core, reports its prediction
// Ports:
//   i_clk, i_rst_n (async active-low), i_clear (sync abort back to FILL)
//   i_pix_valid/o_pix_ready/i_pix_sof/i_pix_data : pixel stream in
//   o_nn_data/o_nn_start                         : frame and launch pulse to the nn core
//   i_nn_resp/i_nn_prediction                    : nn core response
//   o_result_valid/o_result/o_result_err         : latched prediction report
//   o_busy                                       : launch or wait in progress
module nn_frame_loader #(
    parameter int         IMG_W     = 28,
    parameter int         IMG_H     = 28,
    parameter logic [7:0] THRESHOLD = 8'd128,
    parameter int         TIMEOUT   = 4096,
    localparam int        NPIX      = IMG_W * IMG_H
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_pix_valid,
    output logic            o_pix_ready,
    input  logic            i_pix_sof,
    input  logic [7:0]      i_pix_data,
    output logic [NPIX-1:0] o_nn_data,
    output logic            o_nn_start,
    input  logic            i_nn_resp,
    input  logic [4:0]      i_nn_prediction,
    output logic            o_result_valid,
    output logic [3:0]      o_result,
    output logic            o_result_err,
    output logic            o_busy
);
    localparam int IW = $clog2(NPIX);
    localparam int TW = $clog2(TIMEOUT) + 1;
    typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT} state_t;
    state_t          r_state, w_next;
    logic [IW-1:0]   r_idx, w_i;
    logic [NPIX-1:0] r_nn_data;
    logic [TW-1:0]   r_tmo;
    logic            r_nn_start, r_result_valid, r_result_err;
    logic [3:0]      r_result;
    logic            w_accept, w_bit, w_last, w_resp, w_tmo;
    assign o_pix_ready    = r_state == S_FILL;
    assign o_busy         = r_state == S_LAUNCH || r_state == S_WAIT;
    assign o_nn_data      = r_nn_data;
    assign o_nn_start     = r_nn_start;
    assign o_result_valid = r_result_valid;
    assign o_result       = r_result;
    assign o_result_err   = r_result_err;
    // clear is folded into every event qualifier so it overrides them all
    assign w_accept = i_pix_valid && o_pix_ready && !i_clear;
    assign w_i      = i_pix_sof ? '0 : r_idx;
    assign w_bit    = i_pix_data >= THRESHOLD;
    assign w_last   = w_accept && w_i == IW'(NPIX - 1);
    assign w_resp   = r_state == S_WAIT && i_nn_resp && !i_clear;
    assign w_tmo    = r_state == S_WAIT && !i_nn_resp && !i_clear && r_tmo == TW'(TIMEOUT - 1);
    always_comb begin
        w_next = r_state;
        if (i_clear) w_next = S_FILL;
        else if (r_state == S_FILL && w_last) w_next = S_LAUNCH;
        else if (r_state == S_LAUNCH) w_next = S_WAIT;
        else if (w_resp || w_tmo) w_next = S_FILL;
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) r_state <= S_FILL;
        else r_state <= w_next;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_idx          <= '0;
            r_nn_data      <= '0;
            r_tmo          <= '0;
            r_nn_start     <= 1'b0;
            r_result_valid <= 1'b0;
            r_result       <= 4'h0;
            r_result_err   <= 1'b0;
        end else begin
            r_nn_start     <= w_last;
            r_result_valid <= w_resp || w_tmo;
            r_tmo          <= r_state == S_LAUNCH ? '0 :
                              (r_state == S_WAIT && !(&r_tmo)) ? r_tmo + 1'b1 : r_tmo;
            if (i_clear) r_idx <= '0;
            else if (w_accept) r_idx <= w_last ? '0 : w_i + 1'b1;
            // a start-of-frame pixel discards whatever partial frame was loaded
            if (w_accept && i_pix_sof) r_nn_data <= NPIX'(w_bit);
            else if (w_accept) r_nn_data[r_idx] <= w_bit;
            if (w_resp) begin
                r_result     <= i_nn_prediction[3:0];
                r_result_err <= i_nn_prediction > 5'd9;
            end else if (w_tmo) begin
                r_result     <= 4'hF;
                r_result_err <= 1'b1;
            end
        end
endmodule
